// File: rtl/ethernet_tx_frame_arbiter.sv
// ethernet_tx_frame_arbiter: round-robin whole-frame arbiter of two AXI-Stream sources onto the Ethernet TX stream.
// Optional frame/truncation counters are enabled with ETH_TX_ARB_STATS_EN.
module ethernet_tx_frame_arbiter #(
   parameter int MAX_BEATS = 190,
   parameter int IDLE_GAP  = 1
) (
   input  logic        i_ethernet_controller_clk,
   input  logic        i_reset_n,
   input  logic        i_s0_tvalid,
   output logic        o_s0_tready,
   input  logic [63:0] i_s0_tdata,
   input  logic [7:0]  i_s0_tkeep,
   input  logic        i_s0_tlast,
   input  logic        i_s1_tvalid,
   output logic        o_s1_tready,
   input  logic [63:0] i_s1_tdata,
   input  logic [7:0]  i_s1_tkeep,
   input  logic        i_s1_tlast,
   output logic        o_m_tvalid,
   input  logic        i_m_tready,
   output logic [63:0] o_m_tdata,
   output logic [7:0]  o_m_tkeep,
   output logic        o_m_tlast,
   output logic        o_m_tuser,
   output logic [1:0]  o_grant,
   output logic        o_busy,
   output logic [15:0] o_frames0,
   output logic [15:0] o_frames1,
   output logic [7:0]  o_trunc_count
);
   typedef enum logic [1:0] {IDLE, BURST, DRAIN, GAP} state_t;
   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam state_t S_END = (IDLE_GAP > 0) ? GAP : IDLE;

   state_t      r_state, w_next;
   logic [1:0]  r_grant, w_pick;
   logic        r_last;
   logic [CW-1:0] r_cnt;
   logic [7:0]  r_gap;
   logic        r_m_tvalid, r_m_tlast, r_m_tuser;
   logic [63:0] r_m_tdata;
   logic [7:0]  r_m_tkeep;
   logic        w_ld, w_rdy, w_accept, w_load, w_limit, w_end, w_trunc, w_s_last;
   logic [63:0] w_s_data;
   logic [7:0]  w_s_keep;

   always_comb begin
      w_ld     = !r_m_tvalid || i_m_tready;
      w_rdy    = (r_state == DRAIN) || (r_state == BURST && w_ld);
      w_accept = w_rdy && (r_grant[0] ? i_s0_tvalid : (r_grant[1] && i_s1_tvalid));
      w_load   = w_accept && r_state == BURST;
      w_s_last = r_grant[1] ? i_s1_tlast : i_s0_tlast;
      w_s_data = r_grant[1] ? i_s1_tdata : i_s0_tdata;
      w_s_keep = r_grant[1] ? i_s1_tkeep : i_s0_tkeep;
      w_limit  = r_cnt == CW'(MAX_BEATS - 1);
      w_end    = w_accept && w_s_last;
      w_trunc  = w_load && !w_s_last && w_limit;
      // r_last==1 means source 1 was served last, so source 0 takes a tie
      w_pick   = (i_s0_tvalid && (!i_s1_tvalid || r_last)) ? 2'b01 : (i_s1_tvalid ? 2'b10 : 2'b00);
      w_next   = r_state;
      case (r_state)
         IDLE:  if (|w_pick) w_next = BURST;
         BURST: w_next = w_end ? S_END : (w_trunc ? DRAIN : BURST);
         DRAIN: if (w_end) w_next = S_END;
         GAP:   if (r_gap == 8'(IDLE_GAP - 1)) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_ethernet_controller_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_last     <= 1'b1;
         r_cnt      <= '0;
         r_gap      <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tlast  <= 1'b0;
         r_m_tuser  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE) r_grant <= w_pick;
         else if (w_end) r_grant <= '0;
         if (w_end) r_last <= r_grant[1];
         r_cnt <= (w_end || w_trunc) ? '0 : (w_load ? r_cnt + CW'(1) : r_cnt);
         r_gap <= (r_state == GAP) ? r_gap + 8'd1 : 8'd0;
         if (w_ld) r_m_tvalid <= w_load;
         if (w_load) begin
            r_m_tdata <= w_s_data;
            r_m_tkeep <= w_s_keep;
            r_m_tlast <= w_s_last || w_limit;
            r_m_tuser <= w_trunc;
         end
      end
   end

   assign o_s0_tready = r_grant[0] && w_rdy;
   assign o_s1_tready = r_grant[1] && w_rdy;
   assign o_m_tvalid  = r_m_tvalid;
   assign o_m_tdata   = r_m_tdata;
   assign o_m_tkeep   = r_m_tkeep;
   assign o_m_tlast   = r_m_tlast;
   assign o_m_tuser   = r_m_tuser;
   assign o_grant     = r_grant;
   assign o_busy      = r_state != IDLE;

`ifdef ETH_TX_ARB_STATS_EN
   logic [15:0] r_frames0, r_frames1;
   logic [7:0]  r_trunc;
   always_ff @(posedge i_ethernet_controller_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_frames0 <= '0;
         r_frames1 <= '0;
         r_trunc   <= '0;
      end else begin
         if (w_end && r_grant[0]) r_frames0 <= r_frames0 + 16'd1;
         if (w_end && r_grant[1]) r_frames1 <= r_frames1 + 16'd1;
         if (w_trunc && r_trunc != 8'hFF) r_trunc <= r_trunc + 8'd1;
      end
   end
   assign o_frames0     = r_frames0;
   assign o_frames1     = r_frames1;
   assign o_trunc_count = r_trunc;
`else
   assign o_frames0     = '0;
   assign o_frames1     = '0;
   assign o_trunc_count = '0;
`endif
endmodule

// File: tb/tb_ethernet_tx_frame_arbiter.sv
// tb_ethernet_tx_frame_arbiter: randomized frames from two sources, checked by a scoreboard
// built from the round-robin / watchdog rules.
module tb_ethernet_tx_frame_arbiter;
   localparam int MAXB = 6;
   localparam int NF   = 12;
   localparam int NB   = 9;

   logic        clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_s0_tvalid = 1'b0, i_s1_tvalid = 1'b0;
   logic [63:0] i_s0_tdata = '0, i_s1_tdata = '0;
   logic [7:0]  i_s0_tkeep = '0, i_s1_tkeep = '0;
   logic        i_s0_tlast = 1'b0, i_s1_tlast = 1'b0;
   logic        i_m_tready = 1'b1;
   logic        o_s0_tready, o_s1_tready, o_m_tvalid, o_m_tlast, o_m_tuser, o_busy;
   logic [63:0] o_m_tdata;
   logic [7:0]  o_m_tkeep, o_trunc_count;
   logic [1:0]  o_grant;
   logic [15:0] o_frames0, o_frames1;

   ethernet_tx_frame_arbiter #(.MAX_BEATS(MAXB), .IDLE_GAP(1)) dut (
      .i_ethernet_controller_clk(clk), .i_reset_n(i_reset_n),
      .i_s0_tvalid(i_s0_tvalid), .o_s0_tready(o_s0_tready), .i_s0_tdata(i_s0_tdata),
      .i_s0_tkeep(i_s0_tkeep), .i_s0_tlast(i_s0_tlast),
      .i_s1_tvalid(i_s1_tvalid), .o_s1_tready(o_s1_tready), .i_s1_tdata(i_s1_tdata),
      .i_s1_tkeep(i_s1_tkeep), .i_s1_tlast(i_s1_tlast),
      .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready), .o_m_tdata(o_m_tdata),
      .o_m_tkeep(o_m_tkeep), .o_m_tlast(o_m_tlast), .o_m_tuser(o_m_tuser),
      .o_grant(o_grant), .o_busy(o_busy), .o_frames0(o_frames0), .o_frames1(o_frames1),
      .o_trunc_count(o_trunc_count)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   logic [73:0] exp_q[$];
   int          lens[2][NF];
   logic [63:0] dat[2][NF][NB];
   logic [7:0]  kp[2][NF][NB];
   int          frames_exp[2] = '{0, 0};
   int          trunc_exp = 0;
   int          model_last = 1;
   bit          rdy_rand = 0, gap_en = 1;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      i_m_tready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   logic [73:0] held;
   bit          hold = 0;
   always @(negedge clk) begin
      if (!i_reset_n) hold = 0;
      else begin
         chk("tready_exclusive", o_s0_tready & o_s1_tready, 0);
         if (hold) chk("hold_stable", {o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tuser}, held);
         if (o_m_tvalid && i_m_tready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat got=%0h exp=none", o_m_tdata);
            end else chk("beat", {o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tuser}, exp_q.pop_front());
         end
         hold = o_m_tvalid && !i_m_tready;
         held = {o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tuser};
      end
   end

   task automatic drive(input int s, input logic [63:0] d, input logic [7:0] k, input logic l, input logic v);
      if (s == 0) begin i_s0_tvalid = v; i_s0_tdata = d; i_s0_tkeep = k; i_s0_tlast = l; end
      else        begin i_s1_tvalid = v; i_s1_tdata = d; i_s1_tkeep = k; i_s1_tlast = l; end
   endtask

   task automatic wait_acc(input int s);
      int   t = 0;
      logic r;
      do begin
         @(negedge clk);
         r = (s == 0) ? o_s0_tready : o_s1_tready;
         @(posedge clk); #1;
         t++;
         if (t > 3000) begin
            $display("FAIL accept_timeout src=%0d got=stalled exp=accept", s);
            $fatal(1, "source stalled");
         end
      end while (!r);
   endtask

   task automatic send_frames(input int s, input int nfr);
      for (int f = 0; f < nfr; f++)
         for (int b = 0; b < lens[s][f]; b++) begin
            if (gap_en && b > 0 && $urandom_range(0, 2) == 0) begin
               drive(s, '0, '0, 1'b0, 1'b0);
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            drive(s, dat[s][f][b], kp[s][f][b], b == lens[s][f] - 1, 1'b1);
            wait_acc(s);
         end
      drive(s, '0, '0, 1'b0, 1'b0);
   endtask

   // Expected output of one frame: first MAXB beats survive; an overlong frame ends in a tuser beat
   task automatic push_frame(input int s, input int f);
      int n = (lens[s][f] > MAXB) ? MAXB : lens[s][f];
      for (int b = 0; b < n; b++)
         exp_q.push_back({dat[s][f][b], kp[s][f][b], b == n - 1, lens[s][f] > MAXB && b == n - 1});
      frames_exp[s]++;
      if (lens[s][f] > MAXB) trunc_exp++;
   endtask

   task automatic drain_and_idle(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
      chk({tag, "_drain"}, exp_q.size(), 0);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_busy_idle"}, o_busy, 0);
      chk({tag, "_valid_idle"}, o_m_tvalid, 0);
   endtask

   task automatic check_stats(input string tag);
`ifdef ETH_TX_ARB_STATS_EN
      chk({tag, "_frames0"}, o_frames0, frames_exp[0]);
      chk({tag, "_frames1"}, o_frames1, frames_exp[1]);
      chk({tag, "_trunc"}, o_trunc_count, trunc_exp);
`else
      chk({tag, "_frames0"}, o_frames0, 0);
      chk({tag, "_frames1"}, o_frames1, 0);
      chk({tag, "_trunc"}, o_trunc_count, 0);
`endif
   endtask

   // Both sources always have a frame waiting, so frames strictly alternate
   task automatic run_rr(input int nfr, input string tag);
      int first = (model_last == 1) ? 0 : 1;
      for (int s = 0; s < 2; s++)
         for (int f = 0; f < nfr; f++) begin
            lens[s][f] = $urandom_range(1, NB);
            for (int b = 0; b < NB; b++) begin
               dat[s][f][b] = {8'(s), 8'(f), 8'(b), $urandom(), 8'($urandom())};
               kp[s][f][b]  = 8'($urandom_range(1, 255));
            end
         end
      lens[first][0] = MAXB + 2;
      lens[1 - first][0] = MAXB;
      for (int f = 0; f < nfr; f++) begin
         push_frame(first, f);
         push_frame(1 - first, f);
      end
      fork
         send_frames(0, nfr);
         send_frames(1, nfr);
      join
      model_last = 1 - first;
      drain_and_idle(tag);
      check_stats(tag);
   endtask

   initial begin
      #2;
      chk("rst_valid", o_m_tvalid, 0);
      chk("rst_grant", o_grant, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_tready", {o_s0_tready, o_s1_tready}, 0);
      chk("rst_fields", {o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tuser}, 0);
      check_stats("rst");
      repeat (2) @(posedge clk);
      #1 i_reset_n = 1'b1;
      @(posedge clk); #1;

      gap_en = 0;
      lens[0][0] = 3;
      dat[0][0][0] = 64'h1111_0000_0000_0001; kp[0][0][0] = 8'hFF;
      dat[0][0][1] = 64'h1111_0000_0000_0002; kp[0][0][1] = 8'hFF;
      dat[0][0][2] = 64'h1111_0000_0000_0003; kp[0][0][2] = 8'h0F;
      push_frame(0, 0);
      fork
         send_frames(0, 1);
         begin
            int c = 0;
            while (!o_m_tvalid && c < 10) begin @(posedge clk); #1; c++; end
            chk("latency", c, 2);
            chk("grant_s0", o_grant, 2'b01);
         end
      join
      model_last = 0;
      drain_and_idle("single");
      check_stats("single");

      gap_en = 1;
      rdy_rand = 1;
      run_rr(NF, "rr1");

      rdy_rand = 0;
      drive(1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, 1'b1);
      begin
         int t = 0;
         do begin @(posedge clk); #1; t++; end while (!o_m_tvalid && t < 10);
      end
      chk("pre_reset_valid", o_m_tvalid, 1);
      #1 i_reset_n = 1'b0;
      #1;
      chk("midrst_valid", o_m_tvalid, 0);
      chk("midrst_grant", o_grant, 0);
      chk("midrst_busy", o_busy, 0);
      drive(1, '0, '0, 1'b0, 1'b0);
      exp_q.delete();
      frames_exp = '{0, 0};
      trunc_exp = 0;
      model_last = 1;
      check_stats("midrst");
      repeat (2) @(posedge clk);
      #1 i_reset_n = 1'b1;
      @(posedge clk); #1;

      rdy_rand = 1;
      run_rr(6, "rr2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ethernet_tx_frame_arbiter.md
Name: ethernet_tx_frame_arbiter

Overview:
- Shares the Ethernet controller TX stream input (64-bit data, 8-bit tkeep, tlast) between two AXI-Stream frame sources.
- Arbitrates whole frames round-robin; a frame is never interleaved.
- Registered single-stage output, with a beat-count watchdog that truncates runaway frames.
- Sits in the Ethernet controller clock domain, upstream of the controller/AXI-Stream CDC bridge TX path.

Parameters:
- MAX_BEATS, 190: maximum beats per frame (1518 B / 8, rounded up); the beat that reaches this count is forced last.
- IDLE_GAP, 1: idle cycles inserted after a frame's last beat is loaded into the output register (0 = none).

Ports:
- i_ethernet_controller_clk  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_s0_tvalid / o_s0_tready  in/out  1  source 0 handshake
- i_s0_tdata  in  64  source 0 data
- i_s0_tkeep  in  8  source 0 byte enables
- i_s0_tlast  in  1  source 0 end of frame
- i_s1_tvalid, o_s1_tready, i_s1_tdata, i_s1_tkeep, i_s1_tlast  (same widths)  source 1
- o_m_tvalid  out  1  to controller TX
- i_m_tready  in  1  from controller TX
- o_m_tdata  out  64
- o_m_tkeep  out  8
- o_m_tlast  out  1
- o_m_tuser  out  1  1 = frame truncated by watchdog
- o_grant  out  2  one-hot current grant, 00 when idle
- o_busy  out  1  state != IDLE
- o_frames0, o_frames1  out  16  frame counters (optional feature)
- o_trunc_count  out  8  truncation counter (optional feature)

Behaviour:
- Reset: async on i_reset_n low.
  - All outputs 0; state IDLE; last-served pointer = 1, so source 0 wins the first tie.
- Output register load condition: ld = !o_m_tvalid || i_m_tready.
  - o_m_tvalid clears when i_m_tready && !ld-source beat.
- States: IDLE, BURST, DRAIN, GAP.
- IDLE:
  - Only one source valid: grant it.
  - Both valid: grant the one not last served.
  - Register grant, go to BURST. No tready is asserted in IDLE.
- BURST:
  - o_sN_tready = grant==N && ld; the other source's tready = 0.
  - Each accepted beat is copied to the output register and the beat counter increments.
  - Accepted tlast: o_m_tlast=1, o_m_tuser=0, update last-served pointer, counter cleared. Next state is GAP, or IDLE when IDLE_GAP=0.
  - Accepted beat with count == MAX_BEATS-1 and no tlast: forwarded with o_m_tlast=1, o_m_tuser=1. Go to DRAIN.
- DRAIN:
  - Granted source tready = 1 regardless of i_m_tready; its beats are discarded.
  - On accepted tlast: update pointer, go to GAP/IDLE.
- GAP: counts IDLE_GAP cycles, then IDLE. Inputs are not ready during GAP.
- Latency: tvalid first seen in IDLE at cycle N → granted and accepted at N+1 → o_m_tvalid at N+2.
  - Back-to-back beats stream at 1 beat/cycle while i_m_tready=1.
- Backpressure: i_m_tready=0 with o_m_tvalid=1 holds all output fields stable and deasserts the granted tready.
- tkeep is passed through unmodified; on a truncated beat the source tkeep is kept.
- Simultaneous tlast and watchdog limit on the same beat: treated as a normal tlast, with o_m_tuser=0.
- Source tvalid dropping mid-frame: BURST holds the grant; no timeout other than beat count.
- Reset mid-frame: output is dropped immediately; the sources are not notified.

Optional Feature:
- Macro: ETH_TX_ARB_STATS_EN.
- Defined:
  - o_frames0/o_frames1 increment (wrapping at 16 bits) when the granted source's tlast is accepted, in BURST or DRAIN.
  - o_trunc_count increments on each watchdog truncation, saturating at 255.
  - All three clear on reset.
- Undefined: the ports remain present and are tied to 0; no counter logic is instantiated.

Test Plan:
- Source 0 only sends a 3-beat frame (tkeep FF, FF, 0F) with i_m_tready=1.
  - Output beats appear at cycles N+2..N+4; tlast on the 3rd beat, tkeep 0F, tuser=0; o_grant=01 during the frame.
- Both sources assert valid together after reset, each with a 2-beat frame.
  - Source 0 frame is output first, then 1 IDLE_GAP cycle, then the source 1 frame; the beats do not interleave.
- Source 1 sends frames continuously while source 0 sends one frame.
  - Grants alternate 10, 01, 10; frame counts with STATS_EN: o_frames1=2, o_frames0=1.
- i_m_tready toggles 1,0,1,0 during a 4-beat frame.
  - Each beat is held stable while not ready; exactly 4 beats are output, in order, with tdata intact.
- MAX_BEATS=4 and a 6-beat frame from source 0.
  - The 4th output beat has tlast=1 and tuser=1; beats 5–6 are consumed without output; o_trunc_count=1.
  - The next source 1 frame then outputs normally.
- i_reset_n is pulsed low mid-frame.
  - o_m_tvalid, o_grant and o_busy read 0 immediately; after release, source 0 wins the next tie.
